// File: rtl/qtree_lookup_client_pkg.sv
// Shared definitions for the quadtree lookup client: response entry layout and counter sizing.
package qtree_lookup_client_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_TAG_WIDTH  = 4;

    typedef struct packed {
        logic                      match;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_TAG_WIDTH-1:0]  tag;
    } resp_entry_t;

    // Width needed to count 0..depth inclusive.
    function automatic int occWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/qtree_lookup_client_fifo.sv
// Generic synchronous show-ahead FIFO: the head entry sits on data_o whenever the FIFO is not empty.
// A push while full is ignored unless a pop happens in the same cycle.
module qtree_lookup_client_fifo
    import qtree_lookup_client_pkg::*;
#(
    parameter int DATA_WIDTH = 17,
    parameter int DEPTH      = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [occWidth(DEPTH)-1:0]   count_o
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = occWidth(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_wrPtr;
    logic [PTR_WIDTH-1:0]  r_rdPtr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_doPush;
    logic                  w_doPop;

    assign empty_o  = (r_count == '0);
    assign full_o   = (r_count == CNT_FULL);
    assign count_o  = r_count;
    assign data_o   = r_mem[r_rdPtr];
    assign w_doPop  = pop_i & ~empty_o;
    assign w_doPush = push_i & (~full_o | w_doPop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; consumers only look at data_o while not empty.
    always_ff @(posedge clk_i) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= data_i;
        end
    end

endmodule

// File: rtl/qtree_lookup_client.sv
// Lookup-side client of the quadtree engine: tags requests, issues them, and buffers results behind credits.
// Define QTREE_LOOKUP_CLIENT_ORDER_CHECK_EN to flag results whose tag is out of sequence.
module qtree_lookup_client
    import qtree_lookup_client_pkg::*;
#(
    parameter int KEY_WIDTH  = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [KEY_WIDTH-1:0]  req_key_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    output logic [KEY_WIDTH-1:0]  lookup_data_o,
    output logic [TAG_WIDTH-1:0]  lookup_bypass_o,
    output logic                  lookup_valid_o,
    input  logic                  lookup_valid_i,
    input  logic                  lookup_match_i,
    input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
    input  logic [TAG_WIDTH-1:0]  lookup_bypass_i,
    output logic                  resp_match_o,
    output logic [ADDR_WIDTH-1:0] resp_addr_o,
    output logic [TAG_WIDTH-1:0]  resp_tag_o,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic                  idle_o,
    output logic                  err_o
);

    localparam int OCC_WIDTH   = occWidth(FIFO_DEPTH);
    localparam int ENTRY_WIDTH = 1 + ADDR_WIDTH + TAG_WIDTH;
    localparam logic [OCC_WIDTH-1:0] OCC_MAX = OCC_WIDTH'(FIFO_DEPTH);

    typedef struct packed {
        logic                  match;
        logic [ADDR_WIDTH-1:0] addr;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    logic [OCC_WIDTH-1:0]   r_occ;
    logic [TAG_WIDTH-1:0]   r_tagCnt;
    logic                   r_lookupValid;
    logic [KEY_WIDTH-1:0]   r_lookupData;
    logic [TAG_WIDTH-1:0]   r_lookupBypass;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_spurious;
    logic                   w_overflow;
    logic                   w_orderErr;
    logic                   w_fifoEmpty;
    logic                   w_fifoFull;
    logic [OCC_WIDTH-1:0]   w_unusedCount;
    logic [ENTRY_WIDTH-1:0] w_pushData;
    logic [ENTRY_WIDTH-1:0] w_headData;
    entry_t                 w_pushEntry;
    entry_t                 w_headEntry;

    // occ counts every accepted request until its response leaves, so a slot always exists for it.
    assign req_ready_o  = (r_occ < OCC_MAX);
    assign idle_o       = (r_occ == '0);
    assign w_accept     = req_valid_i & req_ready_o;
    assign resp_valid_o = ~w_fifoEmpty;
    assign w_pop        = resp_valid_o & resp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tagCnt       <= '0;
            r_lookupValid  <= 1'b0;
            r_lookupData   <= '0;
            r_lookupBypass <= '0;
        end else begin
            r_lookupValid <= w_accept;
            if (w_accept) begin
                r_lookupData   <= req_key_i;
                r_lookupBypass <= r_tagCnt;
                r_tagCnt       <= r_tagCnt + 1'b1;
            end
        end
    end

    assign lookup_valid_o  = r_lookupValid;
    assign lookup_data_o   = r_lookupData;
    assign lookup_bypass_o = r_lookupBypass;

    // With nothing outstanding, any result must be stale or bogus and is never stored.
    assign w_spurious = lookup_valid_i & idle_o;
    assign w_push     = lookup_valid_i & ~idle_o;
    assign w_overflow = w_push & w_fifoFull & ~w_pop;

    always_comb begin
        w_pushEntry       = '0;
        w_pushEntry.match = lookup_match_i;
        w_pushEntry.addr  = lookup_match_i ? lookup_addr_i : '0;
        w_pushEntry.tag   = lookup_bypass_i;
    end

    assign w_pushData  = w_pushEntry;
    assign w_headEntry = entry_t'(w_headData);

    qtree_lookup_client_fifo #(
        .DATA_WIDTH (ENTRY_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_respFifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_pushData),
        .data_o  (w_headData),
        .empty_o (w_fifoEmpty),
        .full_o  (w_fifoFull),
        .count_o (w_unusedCount)
    );

    assign resp_match_o = resp_valid_o & w_headEntry.match;
    assign resp_addr_o  = resp_valid_o ? w_headEntry.addr : '0;
    assign resp_tag_o   = resp_valid_o ? w_headEntry.tag  : '0;

`ifdef QTREE_LOOKUP_CLIENT_ORDER_CHECK_EN
    logic [TAG_WIDTH-1:0] r_expTag;

    // Resync to the received tag so one slip reports once instead of on every later result.
    assign w_orderErr = w_push & (lookup_bypass_i != r_expTag);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_expTag <= '0;
        end else if (w_push) begin
            r_expTag <= lookup_bypass_i + 1'b1;
        end
    end
`else
    assign w_orderErr = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_spurious | w_overflow | w_orderErr) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

endmodule

// File: tb/tb_qtree_lookup_client.sv
// Self-checking bench for qtree_lookup_client with a fixed-latency engine stand-in and a queue-based reference.
// Order-check scenario runs only when QTREE_LOOKUP_CLIENT_ORDER_CHECK_EN is defined.
module tb_qtree_lookup_client;

    localparam int KEY_WIDTH  = 16;
    localparam int ADDR_WIDTH = 12;
    localparam int TAG_WIDTH  = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int ENG_LAT    = 6;

    typedef struct {
        logic                  m;
        logic [ADDR_WIDTH-1:0] a;
        logic [TAG_WIDTH-1:0]  t;
    } expEntry_t;

    logic                  clk;
    logic                  rst;
    logic [KEY_WIDTH-1:0]  reqKey;
    logic                  reqValid;
    logic                  reqReady;
    logic [KEY_WIDTH-1:0]  lookupData;
    logic [TAG_WIDTH-1:0]  lookupBypassOut;
    logic                  lookupValidOut;
    logic                  engValid;
    logic                  engMatch;
    logic [ADDR_WIDTH-1:0] engAddr;
    logic [TAG_WIDTH-1:0]  engBypass;
    logic                  respMatch;
    logic [ADDR_WIDTH-1:0] respAddr;
    logic [TAG_WIDTH-1:0]  respTag;
    logic                  respValid;
    logic                  respReady;
    logic                  idle;
    logic                  err;

    logic                  pipeV [ENG_LAT];
    logic [KEY_WIDTH-1:0]  pipeK [ENG_LAT];
    logic [TAG_WIDTH-1:0]  pipeT [ENG_LAT];
    logic                  injValid;
    logic                  forceTagEn;
    logic [TAG_WIDTH-1:0]  forceTagVal;

    expEntry_t             expQ [$];
    expEntry_t             tmpEntry;
    int                    mOcc;
    logic [TAG_WIDTH-1:0]  mTag;
    logic                  mErr;
    logic                  errKnown;
    logic                  prevAccept;
    logic [TAG_WIDTH-1:0]  prevTag;
    logic [KEY_WIDTH-1:0]  prevKey;
    int                    totalAccepts;
    int                    vectorCount;
    int                    miscompareCount;

    qtree_lookup_client #(
        .KEY_WIDTH  (KEY_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_key_i       (reqKey),
        .req_valid_i     (reqValid),
        .req_ready_o     (reqReady),
        .lookup_data_o   (lookupData),
        .lookup_bypass_o (lookupBypassOut),
        .lookup_valid_o  (lookupValidOut),
        .lookup_valid_i  (engValid),
        .lookup_match_i  (engMatch),
        .lookup_addr_i   (engAddr),
        .lookup_bypass_i (engBypass),
        .resp_match_o    (respMatch),
        .resp_addr_o     (respAddr),
        .resp_tag_o      (respTag),
        .resp_valid_o    (respValid),
        .resp_ready_i    (respReady),
        .idle_o          (idle),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine stand-in: fixed latency, even keys hit, address is the low key bits scrambled.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENG_LAT; i++) begin
                pipeV[i] <= 1'b0;
                pipeK[i] <= '0;
                pipeT[i] <= '0;
            end
        end else begin
            pipeV[0] <= lookupValidOut;
            pipeK[0] <= lookupData;
            pipeT[0] <= forceTagEn ? forceTagVal : lookupBypassOut;
            for (int i = 1; i < ENG_LAT; i++) begin
                pipeV[i] <= pipeV[i-1];
                pipeK[i] <= pipeK[i-1];
                pipeT[i] <= pipeT[i-1];
            end
        end
    end

    assign engValid  = pipeV[ENG_LAT-1] | injValid;
    assign engMatch  = injValid ? 1'b1 : ~pipeK[ENG_LAT-1][0];
    assign engAddr   = injValid ? 12'h123 : (pipeK[ENG_LAT-1][11:0] ^ 12'h26E);
    assign engBypass = injValid ? 4'h0 : pipeT[ENG_LAT-1];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic expEntry_t refModel(input logic [KEY_WIDTH-1:0] k, input logic [TAG_WIDTH-1:0] t);
        expEntry_t e;
        e.m = ~k[0];
        e.a = e.m ? (k[11:0] ^ 12'h26E) : 12'h000;
        e.t = t;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            miscompareCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // One clock of stimulus: check outputs against the model, predict this edge, then advance.
    task automatic applyStimulus(input logic v, input logic [KEY_WIDTH-1:0] k, input logic rdy);
        logic      predReady;
        logic      accept;
        logic      pop;
        expEntry_t e;
        reqValid  = v;
        reqKey    = k;
        respReady = rdy;
        predReady = (mOcc < FIFO_DEPTH);
        checkOutput("req_ready", reqReady, predReady);
        checkOutput("idle", idle, (mOcc == 0));
        if (errKnown) begin
            checkOutput("err", err, mErr);
        end
        if (prevAccept) begin
            checkOutput("issue_valid", lookupValidOut, 1);
            checkOutput("issue_tag", lookupBypassOut, prevTag);
            checkOutput("issue_key", lookupData, prevKey);
        end else begin
            checkOutput("issue_quiet", lookupValidOut, 0);
        end
        accept = v & predReady;
        pop    = (respValid === 1'b1) & rdy;
        if (pop) begin
            if (expQ.size() == 0) begin
                checkOutput("resp_extra", respValid, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("resp_match", respMatch, e.m);
                checkOutput("resp_addr", respAddr, e.a);
                checkOutput("resp_tag", respTag, e.t);
            end
        end
        if (accept) begin
            expQ.push_back(refModel(k, mTag));
            prevTag = mTag;
            prevKey = k;
            mTag    = mTag + 1'b1;
            totalAccepts++;
        end
        prevAccept = accept;
        mOcc = mOcc + int'(accept) - int'(pop);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst       = 1'b1;
        reqValid  = 1'b0;
        respReady = 1'b0;
        injValid  = 1'b0;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        expQ.delete();
        mOcc       = 0;
        mTag       = '0;
        mErr       = 1'b0;
        prevAccept = 1'b0;
    endtask

    task automatic waitResp(input int budget);
        int n = 0;
        while (respValid !== 1'b1 && n < budget) begin
            applyStimulus(1'b0, '0, 1'b0);
            n++;
        end
        checkOutput("wait_resp", respValid, 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (mOcc != 0 && n < budget) begin
            applyStimulus(1'b0, '0, 1'b1);
            n++;
        end
        checkOutput("drain_idle", idle, 1);
    endtask

    initial begin
        int startAccepts;
        int n;
        vectorCount     = 0;
        miscompareCount = 0;
        totalAccepts    = 0;
        errKnown        = 1'b1;
        forceTagEn      = 1'b0;
        forceTagVal     = '0;
        injValid        = 1'b0;
        reqKey          = '0;
        rst             = 1'b1;
        reqValid        = 1'b0;
        respReady       = 1'b0;
        @(negedge clk);
        doReset();

        checkOutput("rst_ready", reqReady, 1);
        checkOutput("rst_idle", idle, 1);
        checkOutput("rst_lvalid", lookupValidOut, 0);
        checkOutput("rst_ldata", lookupData, 0);
        checkOutput("rst_lbypass", lookupBypassOut, 0);
        checkOutput("rst_rvalid", respValid, 0);
        checkOutput("rst_rmatch", respMatch, 0);
        checkOutput("rst_raddr", respAddr, 0);
        checkOutput("rst_rtag", respTag, 0);
        checkOutput("rst_err", err, 0);

        $display("[TB] single request");
        applyStimulus(1'b1, 16'h1234, 1'b0);
        waitResp(30);
        checkOutput("single_match", respMatch, 1);
        checkOutput("single_addr", respAddr, 12'h05A);
        checkOutput("single_tag", respTag, 0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("single_idle", idle, 1);
        checkOutput("single_err", err, 0);

        $display("[TB] miss result zeroes address");
        applyStimulus(1'b1, 16'h0191, 1'b0);
        waitResp(30);
        checkOutput("miss_match", respMatch, 0);
        checkOutput("miss_addr", respAddr, 0);
        applyStimulus(1'b0, '0, 1'b1);

        $display("[TB] backpressure fill");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0);
        end
        repeat (10) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("full_ready", reqReady, 0);
        checkOutput("full_valid", respValid, 1);
        checkOutput("full_err", err, 0);
        drain(40);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'h0200 + 16'(i), 1'b1);
        end
        drain(40);

        $display("[TB] tag wrap");
        doReset();
        startAccepts = totalAccepts;
        n = 0;
        while (totalAccepts - startAccepts < 18 && n < 80) begin
            applyStimulus(1'b1, 16'h0300 + 16'(n), 1'b1);
            n++;
        end
        checkOutput("wrap_tag", lookupBypassOut, 4'd1);
        drain(40);

        $display("[TB] accept and pop together from full");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'(i * 2), 1'b0);
        end
        repeat (10) applyStimulus(1'b0, '0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, 16'($urandom), 1'b1);
        end
        drain(40);

        $display("[TB] reset while lookups in flight");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h0400 + 16'(i), 1'b1);
        end
        doReset();
        repeat (12) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("midrst_err", err, 0);

        $display("[TB] spurious result");
        applyStimulus(1'b0, '0, 1'b0);
        injValid = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        injValid = 1'b0;
        mErr = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("spur_err", err, 1);
        checkOutput("spur_dropped", respValid, 0);
        applyStimulus(1'b1, 16'h0500, 1'b0);
        waitResp(30);
        applyStimulus(1'b0, '0, 1'b1);
        repeat (3) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("spur_sticky", err, 1);
        doReset();
        checkOutput("spur_clear", err, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0));
        end
        drain(80);

`ifdef QTREE_LOOKUP_CLIENT_ORDER_CHECK_EN
        $display("[TB] out-of-order tag");
        doReset();
        applyStimulus(1'b1, 16'h0A00, 1'b1);
        applyStimulus(1'b1, 16'h0A02, 1'b1);
        drain(40);
        forceTagEn  = 1'b1;
        forceTagVal = 4'd3;
        errKnown    = 1'b0;
        applyStimulus(1'b1, 16'h0A04, 1'b0);
        tmpEntry = expQ[expQ.size() - 1];
        tmpEntry.t = 4'd3;
        expQ[expQ.size() - 1] = tmpEntry;
        waitResp(30);
        checkOutput("order_err", err, 1);
        checkOutput("order_tag", respTag, 4'd3);
        applyStimulus(1'b0, '0, 1'b1);
        forceTagEn = 1'b0;
        mErr       = 1'b1;
        errKnown   = 1'b1;
        drain(40);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
